riscv_run_ctrl: RTL and testbench

- In-design run controller for the RISCVunicycle core: the hardware counterpart of the clock/reset stepping the test bench does by hand.
- A host (debug UART bridge or bench) issues commands over a valid/ready port. The block drives the core's reset and clock-enable so the core can be reset, single/N-stepped, run freely, or halted.
- Reports halt cause, retired-cycle count and a done pulse. Sits between the board clock domain and the core; it does not gate the clock itself.

---
 rtl/riscv_run_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_run_ctrl
//
// Run controller for the RISCVunicycle core. A host (debug UART bridge or a
// bench) sends commands over a valid/ready port. The block drives the core's
// reset and clock-enable so the core can be reset, stepped N cycles, run freely
// or halted. It never gates the clock itself, only the enable.
//
// Optional build macro: RUNCTRL_BREAKPOINT_EN
//   Adds bp_en / bp_addr. A PC match suppresses cpu_en in the same cycle and
//   halts with cause 4. The first enabled cycle after a STEP/RUN acceptance
//   ignores the match so execution can resume from a breakpoint.
//
// Ports:
//   clock        in   system clock, rising edge
//   rst          in   synchronous active-high block reset
//   cmd_valid    in   host command valid
//   cmd_ready    out  controller accepts a command this cycle
//   cmd_op       in   00 RESET_CPU, 01 STEP, 10 RUN, 11 HALT
//   cmd_count    in   STEP cycle count (0 behaves as 1)
//   cpu_rst      out  core reset, active-high
//   cpu_en       out  core clock-enable
//   cpu_pc       in   current core PC
//   cpu_ebreak   in   core executing EBREAK this cycle
//   bp_en        in   breakpoint enable        (RUNCTRL_BREAKPOINT_EN only)
//   bp_addr      in   breakpoint PC            (RUNCTRL_BREAKPOINT_EN only)
//   halted       out  high while halted
//   done         out  one-cycle pulse on every entry to the halted state
//   halt_cause   out  0 reset, 1 step done, 2 ebreak, 3 host halt, 4 breakpoint
//   cycle_count  out  enabled cycles since last CPU reset (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RESET | core held in reset for RST_CYCLES cycles
// S_HALT  | core idle, waiting for a host command
// S_STEP  | core enabled for a bounded number of cycles
// S_RUN   | core enabled until HALT, EBREAK, breakpoint or reset
// -----------------------------------------------------------------------------
module riscv_run_ctrl #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cpu_rst,
    output logic             cpu_en,
    input  logic [XLEN-1:0]  cpu_pc,
    input  logic             cpu_ebreak,
`ifdef RUNCTRL_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [XLEN-1:0]  bp_addr,
`endif
    output logic             halted,
    output logic             done,
    output logic [2:0]       halt_cause,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_HALT  = 2'd1,
        S_STEP  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    localparam logic [2:0] CAUSE_RESET  = 3'd0;
    localparam logic [2:0] CAUSE_STEP   = 3'd1;
    localparam logic [2:0] CAUSE_EBREAK = 3'd2;
    localparam logic [2:0] CAUSE_HOST   = 3'd3;
    localparam logic [2:0] CAUSE_BP     = 3'd4;

    localparam int            RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    state_t           state, state_nxt;
    logic [RW-1:0]    rst_cnt, rst_cnt_nxt;
    // remaining enabled cycles minus one; the step ends when it reads zero
    logic [CNT_W-1:0] step_rem, step_rem_nxt;
    logic [2:0]       cause_nxt;
    logic             enter_halt;
    logic             cc_clr;
    logic             cmd_fire;
    logic             run_like;
    logic             bp_hit;
    logic             ebreak_hit;

    assign run_like  = (state == S_STEP) || (state == S_RUN);
    assign cmd_ready = (state == S_HALT) || (state == S_RUN);
    assign cpu_rst   = (state == S_RESET);
    assign halted    = (state == S_HALT);
    assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef RUNCTRL_BREAKPOINT_EN
    // Set by any STEP/RUN acceptance, cleared after the next enabled cycle,
    // so the instruction sitting on the breakpoint can be executed.
    logic bp_skip;
    logic arm_skip;

    assign arm_skip = cmd_fire && ((cmd_op == OP_STEP) || (cmd_op == OP_RUN));
    assign bp_hit   = run_like && bp_en && (cpu_pc == bp_addr) && !bp_skip;

    always_ff @(posedge clock) begin
        if (rst) begin
            bp_skip <= 1'b0;
        end else if (arm_skip) begin
            bp_skip <= 1'b1;
        end else if (run_like) begin
            bp_skip <= 1'b0;
        end
    end
`else
    // PC only matters when breakpoints are built in.
    logic pc_unused;
    assign pc_unused = ^cpu_pc;
    assign bp_hit    = 1'b0;
`endif

    // The breakpoint is the only thing allowed to override the state decode.
    assign cpu_en     = run_like && !bp_hit;
    assign ebreak_hit = cpu_en && cpu_ebreak;

    always_comb begin
        state_nxt    = state;
        rst_cnt_nxt  = rst_cnt;
        step_rem_nxt = step_rem;
        cause_nxt    = halt_cause;
        enter_halt   = 1'b0;
        cc_clr       = 1'b0;

        case (state)
            S_RESET: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt   = S_HALT;
                    rst_cnt_nxt = '0;
                    cause_nxt   = CAUSE_RESET;
                    enter_halt  = 1'b1;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end

            S_HALT: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RESET: begin
                            state_nxt   = S_RESET;
                            rst_cnt_nxt = '0;
                            cc_clr      = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt    = S_STEP;
                            step_rem_nxt = (cmd_count == '0) ? '0 : cmd_count - 1'b1;
                        end
                        OP_RUN: begin
                            state_nxt = S_RUN;
                        end
                        default: begin
                            // HALT while halted: accepted, nothing changes
                        end
                    endcase
                end
            end

            S_STEP: begin
                if (bp_hit) begin
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_BP;
                    enter_halt = 1'b1;
                end else if (ebreak_hit) begin
                    // ebreak wins over the step ending on the same cycle
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_EBREAK;
                    enter_halt = 1'b1;
                end else if (step_rem == '0) begin
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_STEP;
                    enter_halt = 1'b1;
                end else begin
                    step_rem_nxt = step_rem - 1'b1;
                end
            end

            S_RUN: begin
                if (cmd_fire && (cmd_op == OP_RESET)) begin
                    state_nxt   = S_RESET;
                    rst_cnt_nxt = '0;
                    cc_clr      = 1'b1;
                end else if (bp_hit) begin
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_BP;
                    enter_halt = 1'b1;
                end else if (ebreak_hit) begin
                    // ebreak wins over a host HALT on the same cycle
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_EBREAK;
                    enter_halt = 1'b1;
                end else if (cmd_fire && (cmd_op == OP_HALT)) begin
                    state_nxt  = S_HALT;
                    cause_nxt  = CAUSE_HOST;
                    enter_halt = 1'b1;
                end
                // STEP/RUN while running are accepted and dropped
            end

            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= S_RESET;
            rst_cnt     <= '0;
            step_rem    <= '0;
            done        <= 1'b0;
            halt_cause  <= CAUSE_RESET;
            cycle_count <= '0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            step_rem   <= step_rem_nxt;
            done       <= enter_halt;
            halt_cause <= cause_nxt;
            if (cc_clr) begin
                cycle_count <= '0;
            end else if (cpu_en) begin
                cycle_count <= cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_run_ctrl
//
// Drives host commands into riscv_run_ctrl and predicts, per command, how many
// enabled cycles the core gets, which halt cause results and where the retired
// cycle count ends up. A trivial core model advances the PC by 4 on each
// enabled cycle so breakpoints (when built in) have something to match.
// -----------------------------------------------------------------------------
module tb_riscv_run_ctrl;

    localparam int XLEN       = 32;
    localparam int CNT_W      = 16;
    localparam int RST_CYCLES = 4;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cpu_rst;
    logic             cpu_en;
    logic [XLEN-1:0]  cpu_pc;
    logic             cpu_ebreak = 1'b0;
    logic             halted;
    logic             done;
    logic [2:0]       halt_cause;
    logic [31:0]      cycle_count;
`ifdef RUNCTRL_BREAKPOINT_EN
    logic             bp_en = 1'b0;
    logic [XLEN-1:0]  bp_addr = '0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_cc;
    logic [2:0]  model_cause;

    riscv_run_ctrl #(
        .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cpu_rst    (cpu_rst),
        .cpu_en     (cpu_en),
        .cpu_pc     (cpu_pc),
        .cpu_ebreak (cpu_ebreak),
`ifdef RUNCTRL_BREAKPOINT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
`endif
        .halted     (halted),
        .done       (done),
        .halt_cause (halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // stand-in core: one instruction (4 bytes) per enabled cycle
    always @(posedge clock) begin
        if (cpu_rst)     cpu_pc <= '0;
        else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: enabled-cycle count and cause for one STEP/RUN command.
    function automatic void predict(input logic [1:0] op, input int cnt, input int eb,
                                    input int ha, output int en, output logic [2:0] cause);
        int n;
        if (op == OP_STEP) begin
            n = (cnt == 0) ? 1 : cnt;
            if (eb >= 1 && eb <= n) begin en = eb; cause = 3'd2; end
            else                    begin en = n;  cause = 3'd1; end
        end else begin
            if (eb >= 1 && eb <= ha) begin en = eb; cause = 3'd2; end
            else                     begin en = ha; cause = 3'd3; end
        end
    endfunction

    // Called on the negedge where the core is first in reset with rst low.
    task automatic wait_reset_release();
        int n = 0;
        int guard = 0;
        while (!halted && guard < 50) begin
            if (cpu_rst) n++;
            @(negedge clock);
            guard++;
        end
        chk("rst_len", n, RST_CYCLES);
        chk("rst_halted", halted, 1);
        chk("rst_done", done, 1);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cc", cycle_count, 0);
        chk("rst_released", cpu_rst, 0);
        model_cause = 3'd0;
        @(negedge clock);
        chk("rst_done_width", done, 0);
    endtask

    task automatic pin_reset(input int r);
        cmd_valid  = 1'b0;
        cpu_ebreak = 1'b0;
        rst        = 1'b1;
        @(negedge clock);
        chk("pin_cpu_rst", cpu_rst, 1);
        chk("pin_cpu_en", cpu_en, 0);
        chk("pin_ready", cmd_ready, 0);
        chk("pin_halted", halted, 0);
        chk("pin_done", done, 0);
        chk("pin_cause", halt_cause, 0);
        chk("pin_cc", cycle_count, 0);
        repeat (r - 1) @(negedge clock);
        rst      = 1'b0;
        model_cc = '0;
        wait_reset_release();
    endtask

    // Present one command at a negedge while halted; returns one cycle later.
    task automatic issue(input logic [1:0] op, input int cnt);
        chk("ready_in_halt", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(cnt);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Observe a STEP/RUN until halt; inject ebreak / host HALT / noise.
    task automatic watch(input logic [1:0] op, input int eb, input int ha,
                         input int exp_en, input logic [2:0] exp_cause,
                         input int exp_idle, input bit noise);
        int en = 0;
        int idle = 0;
        int guard = 0;
        bit ready_seen = 1'b0;
        while (!halted && guard < 500) begin
            cmd_valid  = 1'b0;
            cpu_ebreak = 1'b0;
            if (cpu_en) begin
                en++;
                if (op == OP_STEP && cmd_ready) ready_seen = 1'b1;
                if (en == eb) cpu_ebreak = 1'b1;
                if (op == OP_RUN) begin
                    if (en == ha) begin
                        cmd_valid = 1'b1;
                        cmd_op    = OP_HALT;
                    end else if (noise && $urandom_range(0, 3) == 0) begin
                        cmd_valid = 1'b1;
                        cmd_op    = ($urandom_range(0, 1) == 1) ? OP_STEP : OP_RUN;
                        cmd_count = CNT_W'($urandom_range(0, 5));
                    end
                end
            end else begin
                idle++;
            end
            @(negedge clock);
            guard++;
        end
        cmd_valid   = 1'b0;
        cpu_ebreak  = 1'b0;
        model_cc    = model_cc + 32'(exp_en);
        model_cause = exp_cause;
        chk("halt_reached", halted, 1);
        chk("en_cycles", en, exp_en);
        chk("idle_cycles", idle, exp_idle);
        chk("halt_done", done, 1);
        chk("halt_cause", halt_cause, exp_cause);
        chk("halt_cc", cycle_count, model_cc);
        if (op == OP_STEP) chk("step_ready_low", ready_seen, 0);
        @(negedge clock);
        chk("done_width", done, 0);
        chk("halt_en_off", cpu_en, 0);
    endtask

    task automatic do_step(input int cnt, input int eb);
        int en;
        logic [2:0] cause;
        predict(OP_STEP, cnt, eb, 0, en, cause);
        issue(OP_STEP, cnt);
        watch(OP_STEP, eb, 0, en, cause, 0, 1'b0);
    endtask

    task automatic do_run(input int ha, input int eb, input bit noise);
        int en;
        logic [2:0] cause;
        predict(OP_RUN, 0, eb, ha, en, cause);
        issue(OP_RUN, 0);
        watch(OP_RUN, eb, ha, en, cause, 0, noise);
    endtask

    task automatic do_halt_noop();
        issue(OP_HALT, 0);
        chk("noop_done", done, 0);
        chk("noop_halted", halted, 1);
        chk("noop_cause", halt_cause, model_cause);
    endtask

    task automatic do_reset_cmd();
        issue(OP_RESET, 0);
        model_cc = '0;
        chk("rcmd_cpu_rst", cpu_rst, 1);
        chk("rcmd_cc", cycle_count, 0);
        wait_reset_release();
    endtask

    task automatic run_then_reset_cmd(input int k);
        issue(OP_RUN, 0);
        repeat (k - 1) @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = OP_RESET;
        @(negedge clock);
        cmd_valid = 1'b0;
        model_cc  = '0;
        chk("rrun_cpu_rst", cpu_rst, 1);
        chk("rrun_cpu_en", cpu_en, 0);
        chk("rrun_cc", cycle_count, 0);
        wait_reset_release();
    endtask

    task automatic run_then_pin_reset(input int k, input int r);
        issue(OP_RUN, 0);
        repeat (k) @(negedge clock);
        pin_reset(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sel, cnt, eb, ha;
        model_cc    = '0;
        model_cause = 3'd0;

        pin_reset(2);

        do_step(3, 0);
        chk("step3_cc", cycle_count, 3);
        do_step(0, 0);
        chk("step0_cc", cycle_count, 4);
        do_run(10, 0, 1'b0);
        chk("run10_cc", cycle_count, 14);
        do_run(30, 5, 1'b0);
        do_step(2, 2);
        do_run(6, 6, 1'b0);
        do_halt_noop();
        run_then_pin_reset(7, 1);
        do_step(4, 0);
        run_then_reset_cmd(5);
        do_step(1, 0);
        do_reset_cmd();

`ifdef RUNCTRL_BREAKPOINT_EN
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        issue(OP_RUN, 0);
        watch(OP_RUN, 0, 1000, 4, 3'd4, 1, 1'b0);
        chk("bp_pc", cpu_pc, 32'h10);
        do_step(1, 0);
        chk("bp_resume_pc", cpu_pc, 32'h14);
        bp_en = 1'b0;
`endif

        repeat (40) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                cnt = $urandom_range(0, 6);
                eb  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
                do_step(cnt, eb);
            end else if (sel < 8) begin
                ha = $urandom_range(1, 15);
                eb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 18) : 0;
                do_run(ha, eb, 1'b1);
            end else if (sel == 8) begin
                do_halt_noop();
            end else begin
                if ($urandom_range(0, 1) == 1) do_reset_cmd();
                else run_then_pin_reset($urandom_range(1, 6), $urandom_range(1, 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
